// File: rtl/tp_snoop_bank.sv
// rtl/tp_snoop_bank.sv - snoops RAM writes into per-channel tap registers with immediate or frame-synced update
module tp_snoop_bank #(
    parameter int CH = 4,
    parameter int DW = 8,
    parameter int AW = 9
) (
    input  logic             iODCK,
    input  logic             iRST,
    input  logic [CH*AW-1:0] iSW,
    input  logic             iWEA,
    input  logic [DW-1:0]    iData,
    input  logic [AW-1:0]    iAddress,
    input  logic             iVS,
    input  logic             iMode,
    output logic [CH*DW-1:0] oTP,
    output logic [CH-1:0]    oPEND,
    output logic [CH-1:0]    oUPD
);

    logic [CH-1:0][DW-1:0] cap_q, cap_d;
    logic [CH-1:0][DW-1:0] tp_q, tp_d;
    logic [CH-1:0]         pend_q, pend_d;
    logic [CH-1:0]         upd_q, upd_d;
    logic                  vs_q, vs_d;
    logic                  vs_edge;
    logic                  xfer;
    logic [CH-1:0]         hit;

    assign vs_edge = iVS & ~vs_q;
    // Mode 0 transfers every edge; mode 1 only on the frame-sync rising edge.
    assign xfer    = ~iMode | vs_edge;

    always_comb begin
        hit    = '0;
        cap_d  = cap_q;
        tp_d   = tp_q;
        pend_d = pend_q;
        upd_d  = '0;
        vs_d   = iVS;
        for (int c = 0; c < CH; c++) begin
            hit[c] = iWEA && (iAddress == iSW[c*AW +: AW]);
            if (hit[c]) begin
                cap_d[c] = iData;
            end
            // Transfer uses the capture value from before this edge, so a
            // coincident hit stays pending for the next transfer.
            if (xfer) begin
                tp_d[c]  = cap_q[c];
                upd_d[c] = (cap_q[c] != tp_q[c]);
            end
            if (hit[c]) begin
                pend_d[c] = 1'b1;
            end else if (xfer) begin
                pend_d[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge iODCK) begin
        if (!iRST) begin
            cap_q  <= '0;
            tp_q   <= '0;
            pend_q <= '0;
            upd_q  <= '0;
            vs_q   <= 1'b0;
        end else begin
            cap_q  <= cap_d;
            tp_q   <= tp_d;
            pend_q <= pend_d;
            upd_q  <= upd_d;
            vs_q   <= vs_d;
        end
    end

    assign oTP   = tp_q;
    assign oPEND = pend_q;
    assign oUPD  = upd_q;

endmodule

// File: tb/tb_tp_snoop_bank.sv
// tb/tb_tp_snoop_bank.sv - directed self-checking bench for tp_snoop_bank
module tb_tp_snoop_bank;

    localparam int CH = 4;
    localparam int DW = 8;
    localparam int AW = 9;

    logic             clk = 1'b0;
    logic             rstn;
    logic [CH*AW-1:0] sw;
    logic             wea;
    logic [DW-1:0]    data;
    logic [AW-1:0]    addr;
    logic             vs;
    logic             mode;
    logic [CH*DW-1:0] tp;
    logic [CH-1:0]    pend;
    logic [CH-1:0]    upd;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tp_snoop_bank #(.CH(CH), .DW(DW), .AW(AW)) dut (
        .iODCK    (clk),
        .iRST     (rstn),
        .iSW      (sw),
        .iWEA     (wea),
        .iData    (data),
        .iAddress (addr),
        .iVS      (vs),
        .iMode    (mode),
        .oTP      (tp),
        .oPEND    (pend),
        .oUPD     (upd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input string tag, input logic [31:0] e_tp, input logic [3:0] e_pend, input logic [3:0] e_upd);
        check({tag, ".tp"},   tp,           e_tp);
        check({tag, ".pend"}, {28'd0, pend}, {28'd0, e_pend});
        check({tag, ".upd"},  {28'd0, upd},  {28'd0, e_upd});
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wea  = 1'b1;
        addr = a;
        data = d;
        tick();
        wea  = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        sw   = {9'h1FF, 9'h020, 9'h1FF, 9'h010};
        wea  = 1'b0;
        data = '0;
        addr = '0;
        vs   = 1'b0;
        mode = 1'b0;
        tick();
        tick();
        chk3("reset", 32'h0, 4'b0000, 4'b0000);
        rstn = 1'b1;

        // single write, mode 0: two-edge latency
        wr(9'h010, 8'hA5);
        chk3("m0_hit", 32'h0, 4'b0001, 4'b0000);
        tick();
        chk3("m0_xfer", 32'h000000A5, 4'b0000, 4'b0001);
        tick();
        chk3("m0_idle", 32'h000000A5, 4'b0000, 4'b0000);

        // two channels share one tap address
        wr(9'h1FF, 8'h3C);
        chk3("shared_hit", 32'h000000A5, 4'b1010, 4'b0000);
        tick();
        chk3("shared_xfer", 32'h3C003CA5, 4'b0000, 4'b1010);
        tick();

        // rewriting the same value gives one pulse only
        wr(9'h010, 8'h5A);
        tick();
        chk3("same1", 32'h3C003C5A, 4'b0000, 4'b0001);
        wr(9'h010, 8'h5A);
        chk3("same2_hit", 32'h3C003C5A, 4'b0001, 4'b0000);
        tick();
        chk3("same2_xfer", 32'h3C003C5A, 4'b0000, 4'b0000);

        // mode 1: writes held until frame sync edge
        mode = 1'b1;
        wr(9'h020, 8'h11);
        wr(9'h020, 8'h22);
        tick();
        chk3("m1_hold", 32'h3C003C5A, 4'b0100, 4'b0000);
        vs = 1'b1;
        tick();
        chk3("m1_vs", 32'h3C223C5A, 4'b0000, 4'b0100);
        tick();
        chk3("m1_vs_level", 32'h3C223C5A, 4'b0000, 4'b0000);
        vs = 1'b0;
        tick();

        // hit coincident with vs edge: old value transfers, new stays pending
        vs = 1'b1;
        wr(9'h020, 8'h77);
        chk3("coinc", 32'h3C223C5A, 4'b0100, 4'b0000);
        vs = 1'b0;
        tick();
        vs = 1'b1;
        tick();
        chk3("coinc_next", 32'h3C773C5A, 4'b0000, 4'b0100);
        vs = 1'b0;
        tick();

        // switching to mode 0 flushes pending capture
        wr(9'h010, 8'hC3);
        chk3("flush_pend", 32'h3C773C5A, 4'b0001, 4'b0000);
        mode = 1'b0;
        tick();
        chk3("flush", 32'h3C773CC3, 4'b0000, 4'b0001);

        // reset discards pending data and overrides a hit
        mode = 1'b1;
        wr(9'h010, 8'h99);
        check("rst_pre.pend", {28'd0, pend}, 32'h1);
        rstn = 1'b0;
        wr(9'h010, 8'h99);
        chk3("rst_in", 32'h0, 4'b0000, 4'b0000);
        rstn = 1'b1;
        tick();
        vs = 1'b1;
        tick();
        chk3("rst_vs", 32'h0, 4'b0000, 4'b0000);
        vs = 1'b0;
        mode = 1'b0;

        // first edge after release honours a hit
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        wr(9'h010, 8'h42);
        chk3("post_rst_hit", 32'h0, 4'b0001, 4'b0000);
        tick();
        chk3("post_rst_xfer", 32'h00000042, 4'b0000, 4'b0001);

        // tap address change takes effect on the same edge
        sw = {9'h1FF, 9'h020, 9'h1FF, 9'h055};
        wr(9'h055, 8'h66);
        chk3("sw_change", 32'h00000042, 4'b0001, 4'b0000);
        tick();
        chk3("sw_xfer", 32'h00000066, 4'b0000, 4'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tp_snoop_bank.md
TP_SNOOP_BANK -- requirements
Module: tp_snoop_bank

Interface
REQ-001 The block SHALL have parameter CH, default 4, number of independent tap channels (1..16).
REQ-002 The block SHALL have parameter DW, default 8, data width of RAM write bus and of each tap.
REQ-003 The block SHALL have parameter AW, default 9, RAM address width.
REQ-004 The block SHALL have port iODCK  input  1  sole clock, all logic on rising edge.
REQ-005 The block SHALL have port iRST  input  1  reset, synchronous and active-low.
REQ-006 The block SHALL have port iSW  input  CH*AW  tap address per channel; channel c uses bits [c*AW +: AW].
REQ-007 The block SHALL have port iWEA  input  1  RAM write enable, active high.
REQ-008 The block SHALL have port iData  input  DW  RAM write data.
REQ-009 The block SHALL have port iAddress  input  AW  RAM write address.
REQ-010 The block SHALL have port iVS  input  1  frame sync, level; transfer event is its rising edge.
REQ-011 The block SHALL have port iMode  input  1  0 = immediate update, 1 = frame-synchronised update.
REQ-012 The block SHALL have port oTP  output  CH*DW  tap values; channel c at [c*DW +: DW].
REQ-013 The block SHALL have port oPEND  output  CH  per channel: captured value not yet transferred to oTP.
REQ-014 The block SHALL have port oUPD  output  CH  per channel: one-cycle pulse when oTP value changes.

Function
REQ-015 Per channel, hit = iWEA AND (iAddress == channel tap address); every channel with hit at a rising edge SHALL load iData into its capture register tTP at that edge; several channels may hit the same write.
REQ-016 A channel without hit SHALL hold tTP.
REQ-017 Block SHALL register iVS into vs_d each cycle; vs_edge = iVS AND NOT vs_d.
REQ-018 Mode 0: at every edge oTP[c] SHALL load tTP[c] as held before that edge; write-to-oTP latency = 2 edges (hit at edge n, oTP valid after edge n+1).
REQ-019 Mode 1: oTP[c] SHALL load tTP[c] only at edges where vs_edge is 1, otherwise hold.
REQ-020 Simultaneous hit and vs_edge at same edge: oTP SHALL take the old tTP; new data stays in tTP and oPEND SHALL be 1 afterwards.
REQ-021 oPEND[c] SHALL set at a hit edge and clear at the edge where tTP transfers to oTP with no coincident hit; in mode 0 it SHALL therefore be high exactly 1 cycle per isolated write.
REQ-022 oUPD[c] SHALL be 1 for exactly the cycle after an edge where oTP[c] loaded a value different from its previous value; rewriting the same value SHALL give no pulse.
REQ-023 iMode SHALL be sampled every edge with no pipelining; switching 1->0 SHALL flush pending tTP to oTP at the next edge.
REQ-024 iSW changes SHALL take effect on the same edge; no address latching.
REQ-025 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-026 While iRST = 0 at an edge, tTP, oTP, oPEND, oUPD and vs_d SHALL all be cleared to 0, overriding any hit or vs_edge.
REQ-027 Reset asserted mid-frame in mode 1 SHALL discard pending data; first vs_edge after release with no intervening hit SHALL leave oTP = 0 and oUPD = 0.
REQ-028 After reset release the first edge SHALL already honour hits.

Verification
REQ-029 Defaults, mode 0, iSW ch0 = 9'h010; write 8'hA5 to 9'h010 at edge n -> oTP[7:0] = A5 after edge n+1, oPEND[0] high 1 cycle, oUPD[0] high 1 cycle, other channels stay 0.
REQ-030 Channels 1 and 3 both tap 9'h1FF; write 8'h3C -> both show 3C on same cycle; channels 0/2 unchanged.
REQ-031 Mode 1, write 8'h11 then 8'h22 to ch2 address mid-frame -> oTP ch2 stays 0, oPEND[2] = 1; iVS rises -> ch2 = 22 after that edge, oPEND[2] = 0, single oUPD[2] pulse.
REQ-032 Mode 1, write 8'h77 on same edge as vs_edge -> oTP keeps prior value, oPEND = 1; next vs_edge -> oTP = 77.
REQ-033 Write 8'h5A twice to ch0 in mode 0 -> one oUPD[0] pulse only.
REQ-034 Mode 1, pending 8'h99, assert iRST one cycle, release, pulse iVS -> oTP = 0, oPEND = 0, no oUPD.
